// File: rtl/hazard_scoreboard_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit_if
//
// Purpose
//   Bundles the pipeline-facing signals of hazard_scoreboard_unit: the stage
//   register indices and control bits that come from the pipeline, and the
//   forward selects, stall/flush controls, scoreboard bitmap and performance
//   counters that go back to it. Clock and reset are not in the bundle; they
//   stay plain ports on the unit.
//
// Parameters
//   REG_AW : register-index width (2**REG_AW architectural registers)
//   CNT_W  : performance-counter width
//
// Modports
//   master : the pipeline side (drives the i_* signals, receives the o_* signals)
//   slave  : the hazard unit (receives the i_* signals, drives the o_* signals)
//
// Signals (direction as seen by the hazard unit)
//   i_rs1_d, i_rs2_d             in  REG_AW  source registers in decode
//   i_rs1_e, i_rs2_e, i_rd_e     in  REG_AW  source/destination registers in execute
//   i_rd_m, i_rd_wb              in  REG_AW  destinations in memory / writeback
//   i_regwrite_m, i_regwrite_wb  in  1       stage writes the register file
//   i_res_src_b0_e               in  1       load in execute
//   i_long_issue_e               in  1       long op leaves EX into the long unit
//   i_long_done                  in  1       WB carries a long-op result (dest i_rd_wb)
//   i_pc_src_e                   in  2       01 = branch taken
//   i_jmp_e, i_mret_e            in  1       jump / mret in execute
//   o_fw_a_e, o_fw_b_e           out 2       10 = alu_out_m, 01 = res_wb, 00 = reg file
//   o_fw_a_d, o_fw_b_d           out 1       1 = res_wb into decode
//   o_pc_stall, o_if_id_stall    out 1       front-end stall
//   o_if_id_flush, o_id_ex_flush out 1       pipeline-register flushes
//   o_long_full                  out 1       long unit has MAX_OUT ops outstanding
//   o_pending                    out 2**REG_AW scoreboard bitmap
//   o_stall_cnt, o_flush_cnt     out CNT_W   performance counters
// -----------------------------------------------------------------------------
interface hazard_scoreboard_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);

  logic [REG_AW-1:0]     i_rs1_d;
  logic [REG_AW-1:0]     i_rs2_d;
  logic [REG_AW-1:0]     i_rs1_e;
  logic [REG_AW-1:0]     i_rs2_e;
  logic [REG_AW-1:0]     i_rd_e;
  logic [REG_AW-1:0]     i_rd_m;
  logic [REG_AW-1:0]     i_rd_wb;
  logic                  i_regwrite_m;
  logic                  i_regwrite_wb;
  logic                  i_res_src_b0_e;
  logic                  i_long_issue_e;
  logic                  i_long_done;
  logic [1:0]            i_pc_src_e;
  logic                  i_jmp_e;
  logic                  i_mret_e;

  logic [1:0]            o_fw_a_e;
  logic [1:0]            o_fw_b_e;
  logic                  o_fw_a_d;
  logic                  o_fw_b_d;
  logic                  o_pc_stall;
  logic                  o_if_id_stall;
  logic                  o_if_id_flush;
  logic                  o_id_ex_flush;
  logic                  o_long_full;
  logic [2**REG_AW-1:0]  o_pending;
  logic [CNT_W-1:0]      o_stall_cnt;
  logic [CNT_W-1:0]      o_flush_cnt;

  modport master (
    output i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_rd_m, i_rd_wb,
    output i_regwrite_m, i_regwrite_wb, i_res_src_b0_e,
    output i_long_issue_e, i_long_done, i_pc_src_e, i_jmp_e, i_mret_e,
    input  o_fw_a_e, o_fw_b_e, o_fw_a_d, o_fw_b_d,
    input  o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_flush,
    input  o_long_full, o_pending, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_rd_m, i_rd_wb,
    input  i_regwrite_m, i_regwrite_wb, i_res_src_b0_e,
    input  i_long_issue_e, i_long_done, i_pc_src_e, i_jmp_e, i_mret_e,
    output o_fw_a_e, o_fw_b_e, o_fw_a_d, o_fw_b_d,
    output o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_flush,
    output o_long_full, o_pending, o_stall_cnt, o_flush_cnt
  );

endinterface : hazard_scoreboard_unit_if

// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
//
// Purpose
//   Hazard detection and forwarding control for an in-order pipeline with a
//   side unit for multi-cycle ("long") operations. A registered scoreboard
//   tracks which architectural registers still await a long-op result, and a
//   registered count tracks how many long ops are outstanding. All stall,
//   flush and forward outputs are purely combinational.
//
// Parameters
//   REG_AW  : register-index width (2**REG_AW architectural registers)
//   MAX_OUT : maximum outstanding long ops, 1 .. 2**REG_AW-1
//   CNT_W   : performance-counter width
//
// Ports
//   i_clk : rising-edge clock
//   i_rst : asynchronous, active-high reset
//   hz    : hazard_scoreboard_unit_if.slave (all pipeline signals)
//
// Configuration
//   HAZARD_PERF_CNT_EN : when defined, o_stall_cnt / o_flush_cnt count the
//   cycles with the front-end stall high / with the IF/ID flush high,
//   saturating at all-ones. When undefined both outputs are tied to zero and
//   no counter logic exists.
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit #(
  parameter int REG_AW  = 5,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  hazard_scoreboard_unit_if.slave hz
);

  localparam int              NREG  = 2**REG_AW;
  localparam int              CW    = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0]   MAX_C = CW'(MAX_OUT);

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;

  logic full;
  logic done_v;
  logic issue_acc;
  logic added;
  logic removed;

  // The count always equals the number of set scoreboard bits: a bit that is
  // already set is not counted twice, and a done only retires a bit that is
  // actually pending, so a done arriving after a reset is a no-op.
  // When the unit is full, an issue is refused (the stall makes the pipeline
  // retry) unless a done frees a slot in the same cycle or the destination is
  // already pending and no new slot is needed.
  // NOTE: every signal written in an always_comb gets a default before any
  // conditional assignment, so no path leaves it unassigned and no latch is
  // inferred.
  always_comb begin
    full      = (count_q == MAX_C);
    done_v    = hz.i_long_done && (hz.i_rd_wb != '0) && pending_q[hz.i_rd_wb];
    issue_acc = hz.i_long_issue_e && (hz.i_rd_e != '0)
                && (!full || done_v || pending_q[hz.i_rd_e]);
    added     = issue_acc && !pending_q[hz.i_rd_e];
    // Issue and done on the same index keep the bit set and the count flat.
    removed   = done_v && !(issue_acc && (hz.i_rd_e == hz.i_rd_wb));

    pending_d = pending_q;
    if (done_v) begin
      pending_d[hz.i_rd_wb] = 1'b0;
    end
    if (issue_acc) begin
      pending_d[hz.i_rd_e] = 1'b1;   // applied after the clear: issue wins
    end

    count_d = count_q;
    unique case ({added, removed})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the edge regardless of the
  // order in which simulators evaluate the always blocks.
  // NOTE: the scoreboard is a small flop bitmap rather than a memory, so it
  // takes part in the asynchronous reset like any other register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard detection (combinational)
  // ---------------------------------------------------------------------------
  logic rs1_d_nz;
  logic rs2_d_nz;
  logic rd_e_nz;
  logic rs1_d_hit_e;
  logic rs2_d_hit_e;
  logic load_use;
  logic long_issue_use;
  logic raw_rs1;
  logic raw_rs2;
  logic waw;
  logic full_issue;
  logic stall_any;
  logic redirect;
  logic stall;

  always_comb begin
    rs1_d_nz    = (hz.i_rs1_d != '0);
    rs2_d_nz    = (hz.i_rs2_d != '0);
    rd_e_nz     = (hz.i_rd_e  != '0);
    rs1_d_hit_e = rs1_d_nz && (hz.i_rs1_d == hz.i_rd_e);
    rs2_d_hit_e = rs2_d_nz && (hz.i_rs2_d == hz.i_rd_e);

    // Load result is not available until after MEM.
    load_use       = hz.i_res_src_b0_e && rd_e_nz && (rs1_d_hit_e || rs2_d_hit_e);
    // A long op leaving EX has no result to forward; its destination is
    // marked pending only at the next edge, so cover the gap here.
    long_issue_use = hz.i_long_issue_e && rd_e_nz && (rs1_d_hit_e || rs2_d_hit_e);
    // Pending source, unless the long result is arriving in WB right now and
    // is bypassed into decode. pending_q[0] is never set.
    raw_rs1        = pending_q[hz.i_rs1_d]
                     && !(hz.i_long_done && (hz.i_rd_wb == hz.i_rs1_d));
    raw_rs2        = pending_q[hz.i_rs2_d]
                     && !(hz.i_long_done && (hz.i_rd_wb == hz.i_rs2_d));
    waw            = pending_q[hz.i_rd_e] && hz.i_long_issue_e;
    full_issue     = full && hz.i_long_issue_e;

    stall_any = load_use || long_issue_use || raw_rs1 || raw_rs2 || waw || full_issue;

    // A control-flow redirect discards the stalled front end, so it wins.
    redirect = (hz.i_pc_src_e == 2'b01) || hz.i_jmp_e || hz.i_mret_e;
    stall    = stall_any && !redirect;
  end

  assign hz.o_pc_stall    = stall;
  assign hz.o_if_id_stall = stall;
  assign hz.o_if_id_flush = redirect;
  assign hz.o_id_ex_flush = (hz.i_pc_src_e == 2'b01) || hz.i_mret_e || stall;
  assign hz.o_long_full   = full;
  assign hz.o_pending     = pending_q;

  // ---------------------------------------------------------------------------
  // Forwarding (combinational)
  // ---------------------------------------------------------------------------
  logic wb_fwd_en;

  always_comb begin
    // WB carries a usable result both for normal writes and for long-op
    // completions (which have i_regwrite_m low while they were in M).
    wb_fwd_en = hz.i_regwrite_wb || hz.i_long_done;

    hz.o_fw_a_d = (hz.i_rs1_d != '0) && (hz.i_rs1_d == hz.i_rd_wb) && wb_fwd_en;
    hz.o_fw_b_d = (hz.i_rs2_d != '0) && (hz.i_rs2_d == hz.i_rd_wb) && wb_fwd_en;

    // The younger producer (M) takes priority over WB.
    hz.o_fw_a_e = 2'b00;
    if ((hz.i_rs1_e != '0) && (hz.i_rs1_e == hz.i_rd_m) && hz.i_regwrite_m) begin
      hz.o_fw_a_e = 2'b10;
    end else if ((hz.i_rs1_e != '0) && (hz.i_rs1_e == hz.i_rd_wb) && wb_fwd_en) begin
      hz.o_fw_a_e = 2'b01;
    end

    hz.o_fw_b_e = 2'b00;
    if ((hz.i_rs2_e != '0) && (hz.i_rs2_e == hz.i_rd_m) && hz.i_regwrite_m) begin
      hz.o_fw_b_e = 2'b10;
    end else if ((hz.i_rs2_e != '0) && (hz.i_rs2_e == hz.i_rd_wb) && wb_fwd_en) begin
      hz.o_fw_b_e = 2'b01;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // Saturate instead of wrapping so a long run never reads as small.
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (redirect && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hz.o_stall_cnt = stall_cnt_q;
  assign hz.o_flush_cnt = flush_cnt_q;
`else
  assign hz.o_stall_cnt = '0;
  assign hz.o_flush_cnt = '0;
`endif

endmodule : hazard_scoreboard_unit
